// File: rtl/mem_burst_responder.sv
// Burst responder serving one requester's rd_burst_*/wr_burst_* traffic from an on-chip synchronous RAM.
// Read data arrives RD_LATENCY+1 cycles after accept; write data is taken 1 cycle after each data_req; no backpressure beyond the req/finish handshake.
module mem_burst_responder #(
    parameter int MEM_DATA_BITS = 16,
    parameter int ADDR_BITS     = 24,
    parameter int BUSRT_BITS    = 10,
    parameter int MEM_ADDR_BITS = 12,
    parameter int RD_LATENCY    = 2
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     rd_burst_req,
    input  logic [BUSRT_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,
    input  logic                     wr_burst_req,
    input  logic [BUSRT_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DRAIN,
        WR,
        WR_DRAIN,
        FIN,
        GAP
    } state_t;

    localparam int                        DEPTH   = 1 << MEM_ADDR_BITS;
    localparam logic [MEM_ADDR_BITS-1:0]  IDX_ONE = MEM_ADDR_BITS'(1);
    localparam logic [BUSRT_BITS-1:0]     CNT_ONE = BUSRT_BITS'(1);

    state_t                     state;
    state_t                     nxt;
    logic [MEM_ADDR_BITS-1:0]   idx;
    logic [BUSRT_BITS-1:0]      cnt;
    logic                       is_rd;
    logic                       accept_rd;
    logic                       accept_wr;
    logic                       rd_en;
    logic                       wr_en_d;
    logic [MEM_ADDR_BITS-1:0]   wr_idx;
    logic [RD_LATENCY-1:0]      vpipe;
    logic [MEM_DATA_BITS-1:0]   dpipe [RD_LATENCY];
    logic [MEM_DATA_BITS-1:0]   mem   [DEPTH];

    // Upper address bits select nothing inside this RAM.
    logic addr_hi_unused;
    assign addr_hi_unused = ^{rd_burst_addr[ADDR_BITS-1:MEM_ADDR_BITS],
                              wr_burst_addr[ADDR_BITS-1:MEM_ADDR_BITS]};

    assign busy = (state != IDLE);

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt               = state;
        accept_rd         = 1'b0;
        accept_wr         = 1'b0;
        rd_en             = 1'b0;
        wr_burst_data_req = 1'b0;
        rd_burst_finish   = 1'b0;
        wr_burst_finish   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_burst_req) begin
                    accept_rd = 1'b1;
                    nxt       = (rd_burst_len == '0) ? FIN : RD;
                end else if (wr_burst_req) begin
                    accept_wr = 1'b1;
                    nxt       = (wr_burst_len == '0) ? FIN : WR;
                end
            end
            RD: begin
                rd_en = 1'b1;
                if (cnt == CNT_ONE) nxt = RD_DRAIN;
            end
            // Hold until every issued strobe has left the latency pipe.
            RD_DRAIN: begin
                if (vpipe == '0) nxt = FIN;
            end
            WR: begin
                wr_burst_data_req = 1'b1;
                if (cnt == CNT_ONE) nxt = WR_DRAIN;
            end
            WR_DRAIN: begin
                nxt = FIN;
            end
            FIN: begin
                rd_burst_finish = is_rd;
                wr_burst_finish = !is_rd;
                nxt             = GAP;
            end
            GAP: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            cnt     <= '0;
            is_rd   <= 1'b0;
            wr_en_d <= 1'b0;
            wr_idx  <= '0;
        end else begin
            wr_en_d <= wr_burst_data_req;
            wr_idx  <= idx;
            if (accept_rd) begin
                idx   <= rd_burst_addr[MEM_ADDR_BITS-1:0];
                cnt   <= rd_burst_len;
                is_rd <= 1'b1;
            end else if (accept_wr) begin
                idx   <= wr_burst_addr[MEM_ADDR_BITS-1:0];
                cnt   <= wr_burst_len;
                is_rd <= 1'b0;
            end else if (rd_en || wr_burst_data_req) begin
                idx <= idx + IDX_ONE;
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Strobe pipe: stage 0 captures the strobe with the RAM read, output register adds the final cycle.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            vpipe               <= '0;
            rd_burst_data_valid <= 1'b0;
            rd_burst_data       <= '0;
        end else begin
            vpipe[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            rd_burst_data_valid <= vpipe[RD_LATENCY-1];
            if (vpipe[RD_LATENCY-1]) begin
                rd_burst_data <= dpipe[RD_LATENCY-1];
            end
        end
    end

    // RAM and its data pipe carry no reset so stored frames survive rst.
    always_ff @(posedge mem_clk) begin
        if (wr_en_d) begin
            mem[wr_idx] <= wr_burst_data;
        end
        if (rd_en) begin
            dpipe[0] <= mem[idx];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            dpipe[i] <= dpipe[i-1];
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Scoreboard bench for mem_burst_responder: a requester model drives bursts, a RAM model predicts read data.
module tb_mem_burst_responder;

    logic        mem_clk;
    logic        rst;
    logic        rd_burst_req;
    logic [9:0]  rd_burst_len;
    logic [23:0] rd_burst_addr;
    logic        rd_burst_data_valid;
    logic [15:0] rd_burst_data;
    logic        rd_burst_finish;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [23:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic [15:0] wr_burst_data;
    logic        wr_burst_finish;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] model [0:4095];
    logic [15:0] exp_q [$];
    logic [15:0] wq    [$];

    int st_rd_first, st_rd_last, st_rd_vcnt, st_rd_fin, st_rd_fin_cyc;
    int st_wr_first, st_wr_dreq, st_wr_fin, st_idle;

    mem_burst_responder #(
        .MEM_DATA_BITS(16), .ADDR_BITS(24), .BUSRT_BITS(10),
        .MEM_ADDR_BITS(12), .RD_LATENCY(2)
    ) dut (
        .mem_clk(mem_clk), .rst(rst),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish), .busy(busy)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    // Drives one read and/or write burst. cyc counts negedges after the reqs are set; when the DUT is
    // idle the accept edge precedes cyc 1, so cyc-1 is the number of edges since accept.
    task automatic run_burst(input bit do_rd, input logic [23:0] raddr, input int rlen,
                             input bit do_wr, input logic [23:0] waddr, input int wlen,
                             input bit settle, input string tag);
        logic [11:0] ri;
        logic [11:0] widx;
        logic [15:0] w;
        logic [15:0] want;
        bit          rd_done, wr_done, prev_dreq;
        int          cyc;
        if (settle) repeat (2) @(negedge mem_clk);
        st_rd_first = -1; st_rd_last = -1; st_rd_vcnt = 0; st_rd_fin = 0; st_rd_fin_cyc = -1;
        st_wr_first = -1; st_wr_dreq = 0; st_wr_fin = 0; st_idle = 0;
        exp_q.delete();
        if (do_rd) begin
            for (int i = 0; i < rlen; i++) begin
                ri = raddr[11:0] + 12'(i);
                exp_q.push_back(model[ri]);
            end
        end
        rd_burst_req  = do_rd;
        rd_burst_addr = raddr;
        rd_burst_len  = 10'(rlen);
        wr_burst_req  = do_wr;
        wr_burst_addr = waddr;
        wr_burst_len  = 10'(wlen);
        widx = waddr[11:0];
        prev_dreq = 1'b0;
        rd_done = !do_rd;
        wr_done = !do_wr;
        cyc = 0;
        while (!(rd_done && wr_done) && cyc < 3000) begin
            @(negedge mem_clk);
            cyc++;
            if (prev_dreq) begin
                w = (wq.size() > 0) ? wq.pop_front() : 16'h0000;
                wr_burst_data = w;
                model[widx]   = w;
                widx          = widx + 12'd1;
            end
            prev_dreq = wr_burst_data_req;
            if (wr_burst_data_req) begin
                if (st_wr_first < 0) st_wr_first = cyc;
                st_wr_dreq++;
            end
            if (!busy) st_idle++;
            if (rd_burst_data_valid) begin
                if (st_rd_first < 0) st_rd_first = cyc;
                st_rd_last = cyc;
                st_rd_vcnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_valid: got data=%h, expected no valid", tag, rd_burst_data);
                end else begin
                    want = exp_q.pop_front();
                    if (rd_burst_data !== want) begin
                        errors++;
                        $display("FAIL %s rd_data word %0d: got %h, expected %h", tag, st_rd_vcnt - 1, rd_burst_data, want);
                    end
                end
            end
            if (rd_burst_finish) begin
                st_rd_fin++;
                st_rd_fin_cyc = cyc;
                rd_burst_req  = 1'b0;
                rd_done       = 1'b1;
            end
            if (wr_burst_finish) begin
                st_wr_fin++;
                wr_burst_req = 1'b0;
                wr_done      = 1'b1;
            end
        end
        if (!(rd_done && wr_done)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no finish after %0d cycles, expected finish", tag, cyc);
            rd_burst_req = 1'b0;
            wr_burst_req = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_burst_req = 1'b0; rd_burst_len = '0; rd_burst_addr = '0;
        wr_burst_req = 1'b0; wr_burst_len = '0; wr_burst_addr = '0; wr_burst_data = '0;
        repeat (3) @(negedge mem_clk);
        checks++;
        if ({rd_burst_data_valid, rd_burst_data, rd_burst_finish, wr_burst_data_req, wr_burst_finish, busy} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h rfin=%b dreq=%b wfin=%b busy=%b, expected all 0",
                     rd_burst_data_valid, rd_burst_data, rd_burst_finish, wr_burst_data_req, wr_burst_finish, busy);
        end
        rst = 1'b0;
        @(negedge mem_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_write_read;
        wq = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        run_burst(1'b0, 24'h0, 0, 1'b1, 24'h000010, 4, 1'b1, "t1_wr");
        checks++;
        if (st_wr_dreq != 4) begin errors++; $display("FAIL t1_wr dreq_count: got %0d, expected 4", st_wr_dreq); end
        checks++;
        if (st_wr_first != 1) begin errors++; $display("FAIL t1_wr dreq_start: got cyc %0d, expected 1", st_wr_first); end
        checks++;
        if (st_wr_fin != 1) begin errors++; $display("FAIL t1_wr finish_count: got %0d, expected 1", st_wr_fin); end
        run_burst(1'b1, 24'h000010, 4, 1'b0, 24'h0, 0, 1'b1, "t1_rd");
        checks++;
        if (st_rd_first - 1 != 3) begin errors++; $display("FAIL t1_rd first_valid: got %0d edges after accept, expected 3", st_rd_first - 1); end
        checks++;
        if (st_rd_vcnt != 4 || st_rd_last - st_rd_first + 1 != 4) begin
            errors++;
            $display("FAIL t1_rd valid_run: got %0d valids over %0d cycles, expected 4 consecutive", st_rd_vcnt, st_rd_last - st_rd_first + 1);
        end
        checks++;
        if (st_rd_fin != 1) begin errors++; $display("FAIL t1_rd finish_count: got %0d, expected 1", st_rd_fin); end
    endtask

    task automatic test_priority;
        wq = '{16'h5555, 16'h6666};
        run_burst(1'b1, 24'h000010, 4, 1'b1, 24'h000100, 2, 1'b1, "t2_both");
        checks++;
        if (st_rd_first - 1 != 3) begin errors++; $display("FAIL t2 read_first: got valid %0d edges after accept, expected 3", st_rd_first - 1); end
        checks++;
        if (st_wr_first != st_rd_fin_cyc + 3) begin
            errors++;
            $display("FAIL t2 write_after_read: got first dreq cyc %0d, expected %0d", st_wr_first, st_rd_fin_cyc + 3);
        end
        checks++;
        if (st_wr_dreq != 2 || st_wr_fin != 1) begin
            errors++;
            $display("FAIL t2 write_served: got dreq=%0d fin=%0d, expected 2 and 1", st_wr_dreq, st_wr_fin);
        end
        run_burst(1'b1, 24'h000100, 2, 1'b0, 24'h0, 0, 1'b1, "t2_rdback");
        checks++;
        if (st_rd_vcnt != 2) begin errors++; $display("FAIL t2 rdback_count: got %0d, expected 2", st_rd_vcnt); end
    endtask

    task automatic test_wrap;
        wq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        run_burst(1'b0, 24'h0, 0, 1'b1, 24'h000FFE, 4, 1'b1, "t3_wr");
        checks++;
        if (st_wr_dreq != 4) begin errors++; $display("FAIL t3 dreq_count: got %0d, expected 4", st_wr_dreq); end
        run_burst(1'b1, 24'h000000, 2, 1'b0, 24'h0, 0, 1'b1, "t3_rd0");
        checks++;
        if (st_rd_vcnt != 2) begin errors++; $display("FAIL t3 rd0_count: got %0d, expected 2", st_rd_vcnt); end
        // Upper address bits must be ignored.
        run_burst(1'b1, 24'h123FFE, 4, 1'b0, 24'h0, 0, 1'b1, "t3_rdhi");
        checks++;
        if (st_rd_vcnt != 4) begin errors++; $display("FAIL t3 rdhi_count: got %0d, expected 4", st_rd_vcnt); end
    endtask

    task automatic test_len_zero;
        run_burst(1'b1, 24'h000010, 0, 1'b0, 24'h0, 0, 1'b1, "t4_rd");
        checks++;
        if (st_rd_fin_cyc != 1 || st_rd_fin != 1) begin
            errors++;
            $display("FAIL t4 rd_finish: got cyc %0d count %0d, expected cyc 1 count 1", st_rd_fin_cyc, st_rd_fin);
        end
        checks++;
        if (st_rd_vcnt != 0 || st_wr_dreq != 0) begin
            errors++;
            $display("FAIL t4 rd_no_data: got valid=%0d dreq=%0d, expected 0 and 0", st_rd_vcnt, st_wr_dreq);
        end
        run_burst(1'b0, 24'h0, 0, 1'b1, 24'h000020, 0, 1'b1, "t4_wr");
        checks++;
        if (st_wr_fin != 1 || st_wr_dreq != 0 || st_rd_vcnt != 0) begin
            errors++;
            $display("FAIL t4 wr_len0: got fin=%0d dreq=%0d valid=%0d, expected 1 0 0", st_wr_fin, st_wr_dreq, st_rd_vcnt);
        end
    endtask

    task automatic test_reset_mid_burst;
        int  vseen;
        int  cyc;
        bit  stray;
        repeat (2) @(negedge mem_clk);
        rd_burst_req = 1'b1; rd_burst_addr = 24'h000010; rd_burst_len = 10'd8;
        vseen = 0; cyc = 0;
        while (vseen < 3 && cyc < 100) begin
            @(negedge mem_clk);
            cyc++;
            if (rd_burst_data_valid) vseen++;
        end
        checks++;
        if (vseen != 3) begin errors++; $display("FAIL t5 reach_cycle3: got %0d valids, expected 3", vseen); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({rd_burst_data_valid, rd_burst_data, rd_burst_finish, wr_burst_data_req, wr_burst_finish, busy} !== 21'h0) begin
            errors++;
            $display("FAIL t5 async_clear: got valid=%b data=%h rfin=%b dreq=%b wfin=%b busy=%b, expected all 0",
                     rd_burst_data_valid, rd_burst_data, rd_burst_finish, wr_burst_data_req, wr_burst_finish, busy);
        end
        rd_burst_req = 1'b0;
        repeat (2) @(negedge mem_clk);
        rst = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge mem_clk);
            if (rd_burst_finish || wr_burst_finish || rd_burst_data_valid) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL t5 no_finish: got finish/valid after abort, expected none"); end
        run_burst(1'b1, 24'h000010, 4, 1'b0, 24'h0, 0, 1'b1, "t5_rd");
        checks++;
        if (st_rd_vcnt != 4 || st_rd_first - 1 != 3) begin
            errors++;
            $display("FAIL t5 reread: got %0d valids first at %0d edges, expected 4 at 3", st_rd_vcnt, st_rd_first - 1);
        end
    endtask

    task automatic test_back_to_back;
        wq.delete();
        for (int i = 0; i < 512; i++) wq.push_back(16'($urandom));
        run_burst(1'b0, 24'h0, 0, 1'b1, 24'h000200, 256, 1'b1, "t6_wr1");
        checks++;
        if (st_wr_dreq != 256 || st_wr_fin != 1) begin
            errors++;
            $display("FAIL t6 wr1: got dreq=%0d fin=%0d, expected 256 and 1", st_wr_dreq, st_wr_fin);
        end
        run_burst(1'b0, 24'h0, 0, 1'b1, 24'h000300, 256, 1'b0, "t6_wr2");
        checks++;
        if (st_wr_first != 3 || st_idle != 1) begin
            errors++;
            $display("FAIL t6 gap: got first dreq cyc %0d idle cycles %0d, expected 3 and 1", st_wr_first, st_idle);
        end
        checks++;
        if (st_wr_dreq != 256 || st_wr_fin != 1) begin
            errors++;
            $display("FAIL t6 wr2: got dreq=%0d fin=%0d, expected 256 and 1", st_wr_dreq, st_wr_fin);
        end
        run_burst(1'b1, 24'h000200, 512, 1'b0, 24'h0, 0, 1'b1, "t6_rd");
        checks++;
        if (st_rd_vcnt != 512 || st_rd_last - st_rd_first + 1 != 512 || st_rd_fin != 1) begin
            errors++;
            $display("FAIL t6 rd_run: got %0d valids over %0d cycles fin=%0d, expected 512 consecutive fin 1",
                     st_rd_vcnt, st_rd_last - st_rd_first + 1, st_rd_fin);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_wrap();
        test_len_zero();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (3) @(negedge mem_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by 2ms, expected bench to finish");
        $fatal(1);
    end

endmodule
